// File: rtl/half_adder_top.sv
// Single-bit half adder: combinational {C,S} = A+B, plus a one-stage registered
// copy with valid tracking and independently saturating operation/carry counters.
module half_adder_top #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             valid_in,
  output logic             C,
  output logic             S,
  output logic             C_q,
  output logic             S_q,
  output logic             valid_out,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  typedef struct packed {
    logic             carry;
    logic             sum;
    logic             vld;
    logic [CNT_W-1:0] ops;
    logic [CNT_W-1:0] carries;
  } state_t;

  state_t state_d, state_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Combinational path is live at all times, reset included.
  assign C = A & B;
  assign S = A ^ B;

  always_comb begin
    // NOTE: assigning every field a default first keeps this block latch-free.
    state_d     = state_q;
    state_d.vld = valid_in;
    if (valid_in) begin
      state_d.carry   = A & B;
      state_d.sum     = A ^ B;
      state_d.ops     = sat_inc(state_q.ops, 1'b1);
      state_d.carries = sat_inc(state_q.carries, A & B);
    end
  end

  // Reset wins over valid_in, discarding any operation presented on that edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign C_q         = state_q.carry;
  assign S_q         = state_q.sum;
  assign valid_out   = state_q.vld;
  assign op_count    = state_q.ops;
  assign carry_count = state_q.carries;

endmodule

// File: tb/tb_half_adder_top.sv
// Self-checking bench for half_adder_top: truth-table vectors, directed
// multi-cycle sequences and randomized traffic against an arithmetic model.
module tb_half_adder_top;

  localparam int W_BIG   = 8;
  localparam int W_SMALL = 2;

  logic clk, rst, A, B, valid_in;
  logic C_b, S_b, C_q_b, S_q_b, vo_b;
  logic C_s, S_s, C_q_s, S_q_s, vo_s;
  logic [W_BIG-1:0]   op_b, cy_b;
  logic [W_SMALL-1:0] op_s, cy_s;

  int checks   = 0;
  int failures = 0;

  half_adder_top #(.CNT_W(W_BIG)) dut_big (
    .clk(clk), .rst(rst), .A(A), .B(B), .valid_in(valid_in),
    .C(C_b), .S(S_b), .C_q(C_q_b), .S_q(S_q_b), .valid_out(vo_b),
    .op_count(op_b), .carry_count(cy_b)
  );

  half_adder_top #(.CNT_W(W_SMALL)) dut_small (
    .clk(clk), .rst(rst), .A(A), .B(B), .valid_in(valid_in),
    .C(C_s), .S(S_s), .C_q(C_q_s), .S_q(S_q_s), .valid_out(vo_s),
    .op_count(op_s), .carry_count(cy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (actual=running required=finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: true operation/carry totals since reset, saturated on compare.
  logic m_cq, m_sq, m_vo;
  int   m_ops, m_carries;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic compare_all();
    int sum_now = int'(A) + int'(B);
    check("big.C",   32'(C_b),   32'(sum_now / 2));
    check("big.S",   32'(S_b),   32'(sum_now % 2));
    check("small.C", 32'(C_s),   32'(sum_now / 2));
    check("small.S", 32'(S_s),   32'(sum_now % 2));
    check("big.C_q", 32'(C_q_b), 32'(m_cq));
    check("big.S_q", 32'(S_q_b), 32'(m_sq));
    check("big.valid_out", 32'(vo_b), 32'(m_vo));
    check("big.op_count",    32'(op_b), 32'(sat(m_ops, W_BIG)));
    check("big.carry_count", 32'(cy_b), 32'(sat(m_carries, W_BIG)));
    check("small.C_q", 32'(C_q_s), 32'(m_cq));
    check("small.S_q", 32'(S_q_s), 32'(m_sq));
    check("small.valid_out", 32'(vo_s), 32'(m_vo));
    check("small.op_count",    32'(op_s), 32'(sat(m_ops, W_SMALL)));
    check("small.carry_count", 32'(cy_s), 32'(sat(m_carries, W_SMALL)));
  endtask

  // One clock edge with the given inputs; model updated, all outputs compared.
  task automatic cycle(input logic r, input logic v, input logic a, input logic b);
    int sum;
    rst = r; valid_in = v; A = a; B = b;
    @(posedge clk);
    sum = int'(a) + int'(b);
    if (r) begin
      m_cq = 1'b0; m_sq = 1'b0; m_vo = 1'b0; m_ops = 0; m_carries = 0;
    end else begin
      m_vo = v;
      if (v) begin
        m_cq = logic'(sum / 2);
        m_sq = logic'(sum % 2);
        m_ops++;
        if (sum == 2) m_carries++;
      end
    end
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [2:0] val;
    logic [1:0] cs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] ab;

    vecs[0] = '{3'd0, 2'b00}; vecs[1] = '{3'd1, 2'b01};
    vecs[2] = '{3'd2, 2'b01}; vecs[3] = '{3'd3, 2'b10};
    vecs[4] = '{3'd4, 2'b00}; vecs[5] = '{3'd5, 2'b01};
    vecs[6] = '{3'd6, 2'b01}; vecs[7] = '{3'd7, 2'b10};

    rst = 1'b1; valid_in = 1'b0; A = 1'b0; B = 1'b0;
    m_cq = 1'b0; m_sq = 1'b0; m_vo = 1'b0; m_ops = 0; m_carries = 0;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);

    // Combinational truth table and truncated 3-bit stimulus, held in reset.
    for (int i = 0; i < 8; i++) begin
      ab = vecs[i].val[1:0];
      {A, B} = ab;
      #10;
      check($sformatf("comb.CS[%0d]", i), 32'({C_b, S_b}), 32'(vecs[i].cs));
    end

    // Single accepted 1+1, then an idle edge.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("seq.C_q", 32'(C_q_b), 32'd1);
    check("seq.S_q", 32'(S_q_b), 32'd0);
    check("seq.valid_out", 32'(vo_b), 32'd1);
    check("seq.op_count", 32'(op_b), 32'd1);
    check("seq.carry_count", 32'(cy_b), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("seq.idle_valid_out", 32'(vo_b), 32'd0);
    check("seq.idle_C_q", 32'(C_q_b), 32'd1);
    check("seq.idle_op_count", 32'(op_b), 32'd1);

    // Stream all four combinations twice.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, k[1], k[0]);
    check("count.op_count", 32'(op_b), 32'd8);
    check("count.carry_count", 32'(cy_b), 32'd2);

    // Saturation on the narrow instance.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("sat.op_count", 32'(op_s), 32'd3);
    check("sat.carry_count", 32'(cy_s), 32'd3);
    check("sat.big_op_count", 32'(op_b), 32'd5);

    // Reset has priority over an operation on the same edge.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("rstprio.C_q", 32'(C_q_b), 32'd0);
    check("rstprio.valid_out", 32'(vo_b), 32'd0);
    check("rstprio.op_count", 32'(op_b), 32'd0);
    check("rstprio.carry_count", 32'(cy_b), 32'd0);
    check("rstprio.C", 32'(C_b), 32'd1);
    check("rstprio.S", 32'(S_b), 32'd0);

    // First edge after reset is accepted.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("post_rst.op_count", 32'(op_b), 32'd1);
    check("post_rst.S_q", 32'(S_q_b), 32'd1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      cycle(logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
